rib_ex_bridge: RTL and testbench

//  Bridge from the core's single-cycle data-bus port (rib_ex_*) to a multi-cycle req/gnt/rvalid peripheral bus.

---
 rtl/rib_ex_bridge_pkg.sv | 16 +
 rtl/rib_ex_bridge_timeout_cnt.sv | 36 +++
 rtl/rib_ex_bridge.sv | 139 +++++++++++++
 tb/tb_rib_ex_bridge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_ex_bridge_pkg.sv
// Shared definitions for the core-to-peripheral bus bridge.
// Provides the bus widths and the bridge FSM state encoding used by
// rib_ex_bridge and its timeout counter.
package rib_ex_bridge_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/rib_ex_bridge_timeout_cnt.sv
// Access timeout counter for the bus bridge.
// Counts up while en is high and saturates at TIMEOUT-1, where expired is
// raised. clr returns the count to zero and has priority over en.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       clear the count
//   en        advance the count
//   expired   count has reached TIMEOUT-1
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/rib_ex_bridge.sv
// Bridge from the core's single-cycle data-bus port to a multi-cycle
// req/gnt/rvalid peripheral bus. The core is stalled through hold_flag_o
// until the slave finishes; every access is bounded by a timeout.
//
// state | meaning
// IDLE  | no access; a core request is latched into the mem_* registers
// REQ   | mem_req_o asserted, waiting for the grant
// WAIT  | read granted, waiting for mem_rvalid_i
// DONE  | one cycle with hold released so the core samples ex_rdata_o
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ex_addr_i/ex_wdata_i/ex_req_i/ex_we_i   core access
//   ex_rdata_o, hold_flag_o  read data and stall back to the core
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  slave request side
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i/mem_err_i  slave response side
//   err_clr_i, err_o         sticky error flag and its clear
module rib_ex_bridge
  import rib_ex_bridge_pkg::*;
#(
  parameter int unsigned            TIMEOUT  = 256,
  parameter logic [MEM_DATA_W-1:0]  ERR_DATA = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_W-1:0] ex_addr_i,
  input  logic [MEM_DATA_W-1:0] ex_wdata_i,
  input  logic                  ex_req_i,
  input  logic                  ex_we_i,
  output logic [MEM_DATA_W-1:0] ex_rdata_o,
  output logic                  hold_flag_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [MEM_DATA_W-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  input  logic                  err_clr_i,
  output logic                  err_o
);

  bridge_state_e         state, state_next;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_next;
  logic                  rdata_load;
  logic                  err_set;
  logic                  expired;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .en      ((state == ST_REQ) || (state == ST_WAIT)),
    .expired (expired)
  );

  // Grant/response are checked before the timeout so a slave answering in
  // the expiry cycle still completes normally.
  always_comb begin
    state_next = state;
    rdata_next = rdata_q;
    rdata_load = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_req_i) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (mem_err_i) begin
            state_next = ST_DONE;
            rdata_load = 1'b1;
            rdata_next = ERR_DATA;
            err_set    = 1'b1;
          end else if (mem_we_o) begin
            state_next = ST_DONE;
          end else if (mem_rvalid_i) begin
            state_next = ST_DONE;
            rdata_load = 1'b1;
            rdata_next = mem_rdata_i;
          end else begin
            state_next = ST_WAIT;
          end
        end else if (expired) begin
          state_next = ST_DONE;
          rdata_load = 1'b1;
          rdata_next = ERR_DATA;
          err_set    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          state_next = ST_DONE;
          rdata_load = 1'b1;
          rdata_next = mem_err_i ? ERR_DATA : mem_rdata_i;
          err_set    = mem_err_i;
        end else if (expired) begin
          state_next = ST_DONE;
          rdata_load = 1'b1;
          rdata_next = ERR_DATA;
          err_set    = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_q     <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && ex_req_i) begin
        mem_we_o    <= ex_we_i;
        mem_addr_o  <= ex_addr_i;
        mem_wdata_o <= ex_wdata_i;
      end
      if (rdata_load) rdata_q <= rdata_next;
      if (err_set) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

  assign mem_req_o   = (state == ST_REQ);
  assign hold_flag_o = ex_req_i && (state != ST_DONE);
  assign ex_rdata_o  = (state == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_rib_ex_bridge.sv
// Self-checking bench for rib_ex_bridge (TIMEOUT=8).
module tb_rib_ex_bridge;

  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_addr_i = '0, ex_wdata_i = '0;
  logic        ex_req_i = 1'b0, ex_we_i = 1'b0;
  logic [31:0] ex_rdata_o;
  logic        hold_flag_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_o;

  rib_ex_bridge #(.TIMEOUT(8), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_req_i(ex_req_i), .ex_we_i(ex_we_i),
    .ex_rdata_o(ex_rdata_o), .hold_flag_o(hold_flag_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .err_clr_i(err_clr_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;

  // Completion monitor: DONE is the cycle where a pending request is not held.
  always @(negedge clk) begin
    if (!rst && ex_req_i && !hold_flag_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done rdata=%h err=%b", ex_rdata_o, err_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (ex_rdata_o !== mon_e.rdata || err_o !== mon_e.err) begin
          errors++;
          $display("FAIL sb_done got rdata=%h err=%b want rdata=%h err=%b",
                   ex_rdata_o, err_o, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  task automatic go_idle(input logic clr);
    @(posedge clk); #1;
    ex_req_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    err_clr_i = clr;
  endtask

  // Drives one access and plays the slave. Ends at the negedge of DONE.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic serr, input logic silent,
                           output int len, output int req_cyc, output int wait_cyc);
    int  gcyc;
    bit  granted;
    bit  done;
    gcyc = 0; granted = 0; done = 0;
    @(posedge clk); #1;
    ex_req_i = 1'b1; ex_we_i = we; ex_addr_i = addr; ex_wdata_i = wdata;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = ~rdata;
    if (err_clr_i) model_err = 1'b0;
    if (silent || serr) begin
      model_rdata = ERR;
      model_err   = 1'b1;
    end else if (!we) begin
      model_rdata = rdata;
    end
    sb_q.push_back('{model_rdata, model_err});
    len = 1; req_cyc = 0; wait_cyc = 0;
    @(negedge clk);
    checks++;
    if (hold_flag_o !== 1'b1) begin
      errors++;
      $display("FAIL first_cycle_hold got %b want 1", hold_flag_o);
    end
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = ~rdata;
      if (mem_req_o) begin
        req_cyc++;
        if (!silent && req_cyc == gnt_dly + 1) begin
          mem_gnt_i = 1'b1; granted = 1; gcyc = cyc;
          mem_err_i = serr && (we || rv_dly == 0);
          if (!we && rv_dly == 0) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
          end
        end
      end else if (granted && !we && cyc == gcyc + rv_dly) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = serr;
      end
      @(negedge clk);
      len++;
      if (!hold_flag_o) begin
        done = 1;
      end else if (mem_req_o) begin
        checks++;
        if (mem_addr_o !== addr || mem_wdata_o !== wdata || mem_we_o !== we) begin
          errors++;
          $display("FAIL req_stable got a=%h d=%h we=%b want a=%h d=%h we=%b",
                   mem_addr_o, mem_wdata_o, mem_we_o, addr, wdata, we);
        end
      end else if (granted) begin
        wait_cyc++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout got no DONE want DONE within 64 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 ||
        ex_rdata_o !== '0 || err_o !== 1'b0 || hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got req=%b we=%b a=%h d=%h rd=%h err=%b hold=%b want all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ex_rdata_o, err_o, hold_flag_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = '0; model_err = 1'b0;
  endtask

  task automatic test_read_fast();
    int len, rq, wt;
    do_access(1'b0, 32'h1000_0004, 32'h0, 0, 0, 32'h1234_5678, 1'b0, 1'b0, len, rq, wt);
    checks++;
    if (len !== 3 || rq !== 1) begin
      errors++;
      $display("FAIL read_fast_latency got len=%0d req=%0d want len=3 req=1", len, rq);
    end
    go_idle(1'b0);
  endtask

  task automatic test_write_delayed();
    int len, rq, wt;
    do_access(1'b1, 32'h1000_0008, 32'hA5A5_A5A5, 4, 0, 32'h0, 1'b0, 1'b0, len, rq, wt);
    checks++;
    if (len !== 7 || rq !== 5) begin
      errors++;
      $display("FAIL write_delayed got len=%0d req=%0d want len=7 req=5", len, rq);
    end
    go_idle(1'b0);
  endtask

  task automatic test_read_wait();
    int len, rq, wt;
    do_access(1'b0, 32'h1000_0010, 32'h0, 0, 3, 32'hCAFE_F00D, 1'b0, 1'b0, len, rq, wt);
    checks++;
    if (len !== 6 || rq !== 1 || wt !== 3) begin
      errors++;
      $display("FAIL read_wait got len=%0d req=%0d wait=%0d want len=6 req=1 wait=3", len, rq, wt);
    end
    go_idle(1'b0);
    @(negedge clk);
    checks++;
    if (ex_rdata_o !== '0) begin
      errors++;
      $display("FAIL idle_rdata got %h want 0", ex_rdata_o);
    end
  endtask

  task automatic test_timeout();
    int len, rq, wt;
    do_access(1'b0, 32'h1000_0020, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, len, rq, wt);
    checks++;
    if (len !== 10 || rq !== 8) begin
      errors++;
      $display("FAIL timeout_len got len=%0d req=%0d want len=10 req=8", len, rq);
    end
    go_idle(1'b1);
    go_idle(1'b0);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err_o);
    end
    model_err = 1'b0;
  endtask

  task automatic test_grant_at_timeout();
    int len, rq, wt;
    do_access(1'b1, 32'h1000_0030, 32'h5A5A_0001, 7, 0, 32'h0, 1'b0, 1'b0, len, rq, wt);
    checks++;
    if (len !== 10 || rq !== 8) begin
      errors++;
      $display("FAIL grant_at_timeout got len=%0d req=%0d want len=10 req=8", len, rq);
    end
    go_idle(1'b0);
  endtask

  task automatic test_err_priority();
    int len, rq, wt;
    go_idle(1'b1);
    do_access(1'b1, 32'h1000_0040, 32'h0000_0042, 0, 0, 32'h0, 1'b1, 1'b0, len, rq, wt);
    go_idle(1'b1);
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_clr_after_set got %b want 0", err_o);
    end
    go_idle(1'b0);
    model_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    int len, rq, wt;
    do_access(1'b0, 32'h1000_0050, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 1'b0, len, rq, wt);
    do_access(1'b0, 32'h1000_0054, 32'h0, 0, 2, 32'h0BAD_F00D, 1'b0, 1'b0, len, rq, wt);
    checks++;
    if (len !== 5 || wt !== 2) begin
      errors++;
      $display("FAIL back_to_back_second got len=%0d wait=%0d want len=5 wait=2", len, wt);
    end
    go_idle(1'b0);
  endtask

  task automatic test_reset_mid();
    int len, rq, wt;
    @(posedge clk); #1;
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h1000_0060;
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; rst = 1'b1; ex_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0 ||
        ex_rdata_o !== '0 || err_o !== 1'b0 || hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got req=%b we=%b a=%h d=%h rd=%h err=%b hold=%b want all 0",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ex_rdata_o, err_o, hold_flag_o);
    end
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b0 || ex_rdata_o !== '0 || hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_rvalid got req=%b rd=%h hold=%b want 0 0 0", mem_req_o, ex_rdata_o, hold_flag_o);
    end
    model_rdata = '0; model_err = 1'b0;
    do_access(1'b1, 32'h1000_0064, 32'h7777_0000, 0, 0, 32'h0, 1'b0, 1'b0, len, rq, wt);
    go_idle(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_fast();
    test_write_delayed();
    test_read_wait();
    test_timeout();
    test_grant_at_timeout();
    test_err_priority();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
